// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - iterative AES MixColumns, COLS_PER_CYCLE columns per clock
// Optional MIX_INV_EN adds in_inv to select InvMixColumns.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
`ifdef MIX_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // STEP wraps to 0 for 4 columns/cycle, so the counter stays at 0 and never passes 3
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       st;
  logic [1:0]   col_cnt;
  logic [127:0] state_q;
  logic [127:0] calc_next;
  logic         last_q;
  logic         inv_q;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiply by a 4-bit coefficient from chained xtime terms
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? x  : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [3:0]  k [4];
    logic [31:0] r;
    logic [7:0]  b;
    logic [1:0]  idx;
    if (inv) k = '{4'he, 4'hb, 4'hd, 4'h9};
    else     k = '{4'h2, 4'h3, 4'h1, 4'h1};
    r = '0;
    for (int row = 0; row < 4; row++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) begin
        idx = 2'(j - row);
        b   = b ^ gmul(c[31-8*j -: 8], k[idx]);
      end
      r[31-8*row -: 8] = b;
    end
    return r;
  endfunction

  always_comb begin
    int base;
    calc_next = state_q;
    base      = int'(col_cnt);
    for (int c = 0; c < 4; c++) begin
      if (c >= base && c < base + COLS_PER_CYCLE) begin
        calc_next[127-32*c -: 32] = last_q ? state_q[127-32*c -: 32]
                                           : mix_col(state_q[127-32*c -: 32], inv_q);
      end
    end
  end

`ifndef MIX_INV_EN
  assign inv_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      col_cnt   <= 2'd0;
      state_q   <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef MIX_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_state;
            last_q   <= in_last;
`ifdef MIX_INV_EN
            inv_q    <= in_inv;
`endif
            col_cnt  <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            st       <= CALC;
          end
        end
        CALC: begin
          state_q <= calc_next;
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST_CNT) begin
            out_valid <= 1'b1;
            st        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - directed bench for mix_columns_seq at 1, 2 and 4 columns/cycle
module tb_mix_columns_seq;

  localparam logic [127:0] V1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V2_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   vld = 3'b000;
  logic [127:0] in_state = '0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   rdy, ov, bsy;
  logic [127:0] os [3];
`ifdef MIX_INV_EN
  logic         in_inv = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_state(in_state), .in_last(in_last),
`ifdef MIX_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bsy[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_state(in_state), .in_last(in_last),
`ifdef MIX_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bsy[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_state(in_state), .in_last(in_last),
`ifdef MIX_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one state to DUT w, then count edges from the accept edge until out_valid
  task automatic xfer(input int w, input logic [127:0] st, input logic last,
                      output int lat, output logic [127:0] res);
    int n;
    @(negedge clk);
    in_state = st;
    in_last  = last;
    vld[w]   = 1'b1;
    n = 0;
    while (!rdy[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 128'(rdy[w]), 128'(1));
    @(posedge clk);
    #1 vld[w] = 1'b0;
    lat = 0;
    while (!ov[w] && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    res = os[w];
  endtask

  initial begin
    int lat;
    logic [127:0] res;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready",  128'(rdy[0]), 128'(1));
    chk("reset_out_valid", 128'(ov[0]),  128'(0));
    chk("reset_out_state", os[0],        128'(0));
    chk("reset_busy",      128'(bsy[0]), 128'(0));

    xfer(0, V1_IN, 1'b0, lat, res);
    chk("v1_c1_state",   res,          V1_OUT);
    chk("v1_c1_latency", 128'(lat),    128'(4));
    chk("v1_c1_busy",    128'(bsy[0]), 128'(1));

    xfer(0, V2_IN, 1'b0, lat, res);
    chk("v2_c1_state",   res,       V2_OUT);
    chk("v2_c1_latency", 128'(lat), 128'(4));
    xfer(1, V2_IN, 1'b0, lat, res);
    chk("v2_c2_state",   res,       V2_OUT);
    chk("v2_c2_latency", 128'(lat), 128'(2));
    xfer(2, V2_IN, 1'b0, lat, res);
    chk("v2_c4_state",   res,       V2_OUT);
    chk("v2_c4_latency", 128'(lat), 128'(1));
    xfer(2, V1_IN, 1'b0, lat, res);
    chk("v1_c4_state",   res,       V1_OUT);

    xfer(0, V1_IN, 1'b1, lat, res);
    chk("last_c1_state",   res,       V1_IN);
    chk("last_c1_latency", 128'(lat), 128'(4));
    xfer(1, V1_IN, 1'b1, lat, res);
    chk("last_c2_state",   res,       V1_IN);
    chk("last_c2_latency", 128'(lat), 128'(2));

    // Back-pressure: first result must hold while a second state waits on in_valid
    out_ready = 1'b0;
    @(posedge clk);
    xfer(0, V1_IN, 1'b0, lat, res);
    chk("bp_first_state", res, V1_OUT);
    in_state = V2_IN;
    in_last  = 1'b0;
    vld[0]   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_state",    os[0],         V1_OUT);
      chk("bp_hold_valid",    128'(ov[0]),   128'(1));
      chk("bp_hold_in_ready", 128'(rdy[0]),  128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid",    128'(ov[0]),  128'(0));
    chk("bp_release_in_ready", 128'(rdy[0]), 128'(1));
    @(posedge clk);
    #1 vld[0] = 1'b0;
    chk("bp_second_accepted", 128'(bsy[0]), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("bp_second_valid", 128'(ov[0]), 128'(1));
    chk("bp_second_state", os[0],       V2_OUT);
    @(posedge clk);

    // Abort in CALC with the counter at column 2
    @(negedge clk);
    in_state = V1_IN;
    vld[0]   = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_out_valid", 128'(ov[0]),  128'(0));
    chk("abort_in_ready",  128'(rdy[0]), 128'(1));
    chk("abort_busy",      128'(bsy[0]), 128'(0));
    chk("abort_out_state", os[0],        128'(0));
    xfer(0, V1_IN, 1'b0, lat, res);
    chk("abort_fresh_state",   res,       V1_OUT);
    chk("abort_fresh_latency", 128'(lat), 128'(4));

`ifdef MIX_INV_EN
    in_inv = 1'b1;
    xfer(0, V1_OUT, 1'b0, lat, res);
    chk("inv_c1_state",   res,       V1_IN);
    chk("inv_c1_latency", 128'(lat), 128'(4));
    xfer(2, V2_OUT, 1'b0, lat, res);
    chk("inv_c4_state",   res,       V2_IN);
    xfer(0, V1_OUT, 1'b1, lat, res);
    chk("inv_last_state", res,       V1_OUT);
    in_inv = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
